// File: rtl/pbch_dmrs_ibar_detector.sv
// Blind PBCH DMRS SSB-index detector: collects DMRS sign bits of one SSB and
// scores all 8 Gold-sequence hypotheses, reporting the best ibar_SSB.
module pbch_dmrs_ibar_detector #(
    parameter int IN_DW   = 32,
    parameter int GOLD_NC = 1600
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [9:0]       N_id_i,
    input  logic             N_id_valid_i,
    input  logic [IN_DW-1:0] s_axis_in_tdata,
    input  logic             s_axis_in_tvalid,
    output logic [2:0]       m_axis_out_tdata,
    output logic             m_axis_out_tvalid,
    output logic [8:0]       score_o,
    output logic             busy_o
);

    // state   | meaning
    // IDLE    | wait for N_id strobe
    // COLLECT | count 720 PBCH REs, keep DMRS sign bits
    // INIT    | load Gold registers for hypothesis ibar
    // WARMUP  | clock Gold registers GOLD_NC times
    // CORR    | compare 288 Gold bits against stored signs
    // COMPARE | keep best hypothesis, advance ibar
    // DONE    | publish result
    typedef enum logic [2:0] {
        S_IDLE, S_COLLECT, S_INIT, S_WARMUP, S_CORR, S_COMPARE, S_DONE
    } state_t;

    localparam int TMAX = (GOLD_NC > 288) ? GOLD_NC : 288;
    localparam int TW   = $clog2(TMAX + 1);

    state_t         state_q, state_d;
    logic [9:0]     nid_q;
    logic [1:0]     v_q;
    logic [1:0]     sym_q;
    logic [7:0]     sc_q;
    logic [287:0]   bits_q;
    logic [2:0]     ibar_q;
    logic [TW-1:0]  tmr_q;
    logic [30:0]    x1_q, x2_q;
    logic [8:0]     match_q, best_q;
    logic [2:0]     best_ibar_q;
    logic [2:0]     tdata_q;
    logic [8:0]     score_q;
    logic           tvalid_q;

    logic           re_acc, last_re, is_dmrs, tmr_tc, c_bit;
    logic           re_sign, im_sign;
    logic [12:0]    hyp_w, nid_w, prod_w;
    logic [30:0]    cinit_w;

    assign re_acc  = (state_q == S_COLLECT) && s_axis_in_tvalid;
    assign last_re = re_acc && (sym_q == 2'd2) && (sc_q == 8'd239);
    assign is_dmrs = (sc_q[1:0] == v_q) &&
                     ((sym_q != 2'd1) || (sc_q < 8'd48) || (sc_q >= 8'd192));
    assign tmr_tc  = (tmr_q == '0);
    assign c_bit   = x1_q[0] ^ x2_q[0];
    assign re_sign = s_axis_in_tdata[IN_DW/2-1];
    assign im_sign = s_axis_in_tdata[IN_DW-1];

    // (ibar+1)*(N_id/4+1) <= 2016, so the shifted product stays in 22 bits
    assign hyp_w   = {10'd0, ibar_q} + 13'd1;
    assign nid_w   = {5'd0, nid_q[9:2]} + 13'd1;
    assign prod_w  = hyp_w * nid_w;
    assign cinit_w = {9'd0, prod_w[10:0], 11'd0} + {21'd0, hyp_w[3:0], 6'd0}
                   + {29'd0, v_q};

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) state_q <= S_IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (N_id_valid_i) state_d = S_COLLECT;
            S_COLLECT: if (last_re) state_d = S_INIT;
            S_INIT:    state_d = S_WARMUP;
            S_WARMUP:  if (tmr_tc) state_d = S_CORR;
            S_CORR:    if (tmr_tc) state_d = S_COMPARE;
            S_COMPARE: state_d = (ibar_q == 3'd7) ? S_DONE : S_INIT;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            nid_q       <= '0;
            v_q         <= '0;
            sym_q       <= '0;
            sc_q        <= '0;
            bits_q      <= '0;
            ibar_q      <= '0;
            tmr_q       <= '0;
            x1_q        <= '0;
            x2_q        <= '0;
            match_q     <= '0;
            best_q      <= '0;
            best_ibar_q <= '0;
            tdata_q     <= '0;
            score_q     <= '0;
            tvalid_q    <= 1'b0;
        end else begin
            tvalid_q <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: begin
                    if (N_id_valid_i) begin
                        nid_q <= N_id_i;
                        v_q   <= N_id_i[1:0];
                        sym_q <= '0;
                        sc_q  <= '0;
                    end
                end
                S_COLLECT: begin
                    if (re_acc) begin
                        if (sc_q == 8'd239) begin
                            sc_q  <= '0;
                            sym_q <= sym_q + 2'd1;
                        end else begin
                            sc_q <= sc_q + 8'd1;
                        end
                        // shifting in from the top leaves DMRS RE m at bits [2m+1:2m]
                        if (is_dmrs) bits_q <= {im_sign, re_sign, bits_q[287:2]};
                        if (last_re) ibar_q <= '0;
                    end
                end
                S_INIT: begin
                    x1_q    <= 31'd1;
                    x2_q    <= cinit_w;
                    match_q <= '0;
                    tmr_q   <= TW'(GOLD_NC - 1);
                end
                S_WARMUP: begin
                    x1_q  <= {x1_q[3] ^ x1_q[0], x1_q[30:1]};
                    x2_q  <= {x2_q[3] ^ x2_q[2] ^ x2_q[1] ^ x2_q[0], x2_q[30:1]};
                    tmr_q <= tmr_tc ? TW'(287) : tmr_q - 1'b1;
                end
                S_CORR: begin
                    x1_q   <= {x1_q[3] ^ x1_q[0], x1_q[30:1]};
                    x2_q   <= {x2_q[3] ^ x2_q[2] ^ x2_q[1] ^ x2_q[0], x2_q[30:1]};
                    // full rotation restores the store for the next hypothesis
                    bits_q <= {bits_q[0], bits_q[287:1]};
                    if (c_bit == bits_q[0]) match_q <= match_q + 9'd1;
                    tmr_q  <= tmr_q - 1'b1;
                end
                S_COMPARE: begin
                    if ((match_q > best_q) || (ibar_q == 3'd0)) begin
                        best_q      <= match_q;
                        best_ibar_q <= ibar_q;
                    end
                    ibar_q <= ibar_q + 3'd1;
                end
                S_DONE: begin
                    tdata_q <= best_ibar_q;
                    score_q <= best_q;
                end
                default: ;
            endcase
        end
    end

    assign m_axis_out_tdata  = tdata_q;
    assign m_axis_out_tvalid = tvalid_q;
    assign score_o           = score_q;

endmodule

// File: tb/tb_pbch_dmrs_ibar_detector.sv
// Randomized scoreboard bench for pbch_dmrs_ibar_detector with a Gold-sequence
// reference model built from the sequence definition.
module tb_pbch_dmrs_ibar_detector;

    localparam int IN_DW = 32;
    localparam int NC    = 200;
    localparam int LEN   = NC + 288 + 31;
    localparam longint LAT = 8 * (NC + 290) + 1;

    logic             clk_i = 1'b0;
    logic             reset_ni;
    logic [9:0]       N_id_i;
    logic             N_id_valid_i;
    logic [IN_DW-1:0] s_axis_in_tdata;
    logic             s_axis_in_tvalid;
    logic [2:0]       m_axis_out_tdata;
    logic             m_axis_out_tvalid;
    logic [8:0]       score_o;
    logic             busy_o;

    pbch_dmrs_ibar_detector #(.IN_DW(IN_DW), .GOLD_NC(NC)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .N_id_i(N_id_i), .N_id_valid_i(N_id_valid_i),
        .s_axis_in_tdata(s_axis_in_tdata), .s_axis_in_tvalid(s_axis_in_tvalid),
        .m_axis_out_tdata(m_axis_out_tdata), .m_axis_out_tvalid(m_axis_out_tvalid),
        .score_o(score_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int ibar; int score; longint cyc; } exp_t;
    exp_t             exp_q[$];
    int               checks = 0;
    int               errors = 0;
    longint           cyc = 0;
    longint           acc;
    logic [IN_DW-1:0] re_mem [720];

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic int cinit_of(int h, int nid);
        return (h + 1) * (nid / 4 + 1) * 2048 + (h + 1) * 64 + nid % 4;
    endfunction

    // c(n) = (x1(n+Nc) + x2(n+Nc)) mod 2, n = 0..287
    function automatic logic [287:0] gold(int cinit);
        int x1 [LEN];
        int x2 [LEN];
        logic [287:0] c;
        for (int n = 0; n < 31; n++) begin
            x1[n] = (n == 0) ? 1 : 0;
            x2[n] = (cinit >> n) & 1;
        end
        for (int n = 0; n + 31 < LEN; n++) begin
            x1[n+31] = (x1[n+3] + x1[n]) % 2;
            x2[n+31] = (x2[n+3] + x2[n+2] + x2[n+1] + x2[n]) % 2;
        end
        for (int j = 0; j < 288; j++) c[j] = 1'((x1[j+NC] + x2[j+NC]) % 2);
        return c;
    endfunction

    function automatic bit dmrs_pos(int cnt, int v);
        int s = cnt / 240;
        int k = cnt % 240;
        return (k % 4 == v) && (s != 1 || k < 48 || k >= 192);
    endfunction

    task automatic build(input int nid, input int ibar, input int nflip);
        logic [287:0] g;
        logic [287:0] fm = '0;
        int m = 0;
        g = gold(cinit_of(ibar, nid));
        while ($countones(fm) < nflip) fm[$urandom_range(287, 0)] = 1'b1;
        g = g ^ fm;
        for (int cnt = 0; cnt < 720; cnt++) begin
            logic [IN_DW-1:0] r = $urandom;
            if (dmrs_pos(cnt, nid % 4)) begin
                r[IN_DW/2-1] = g[2*m];
                r[IN_DW-1]   = g[2*m+1];
                m++;
            end
            re_mem[cnt] = r;
        end
    endtask

    task automatic model(input int nid, output int bi, output int best);
        logic [287:0] st;
        int m = 0;
        for (int cnt = 0; cnt < 720; cnt++)
            if (dmrs_pos(cnt, nid % 4)) begin
                st[2*m]   = re_mem[cnt][IN_DW/2-1];
                st[2*m+1] = re_mem[cnt][IN_DW-1];
                m++;
            end
        best = -1;
        bi = 0;
        for (int h = 0; h < 8; h++) begin
            int sc = 288 - $countones(st ^ gold(cinit_of(h, nid)));
            if (sc > best) begin best = sc; bi = h; end
        end
    endtask

    task automatic send_nid(input int nid);
        @(negedge clk_i);
        N_id_i = 10'(nid);
        N_id_valid_i = 1'b1;
        @(negedge clk_i);
        N_id_valid_i = 1'b0;
    endtask

    task automatic send_res(input bit gaps);
        int idx = 0;
        while (idx < 720) begin
            @(negedge clk_i);
            if (gaps && $urandom_range(1, 0) == 0) begin
                s_axis_in_tvalid = 1'b0;
                s_axis_in_tdata  = $urandom;
            end else begin
                s_axis_in_tdata  = re_mem[idx];
                s_axis_in_tvalid = 1'b1;
                if (idx == 719) acc = cyc + 1;
                idx++;
            end
        end
        @(negedge clk_i);
        s_axis_in_tvalid = 1'b0;
    endtask

    task automatic wait_cyc(input longint t);
        while (cyc < t) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < LAT + 200 && exp_q.size() != 0; i++) @(posedge clk_i);
        chk("result_timeout_pending", exp_q.size(), 0);
    endtask

    task automatic run(input int nid, input int ibar, input int nflip,
                       input bit gaps, input bit push);
        int bi, best;
        exp_t e;
        build(nid, ibar, nflip);
        send_nid(nid);
        chk("busy_in_collect", busy_o, 1);
        send_res(gaps);
        if (push) begin
            model(nid, bi, best);
            e.ibar = bi;
            e.score = best;
            e.cyc = acc + LAT;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (m_axis_out_tvalid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tvalid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tdata", m_axis_out_tdata, e.ibar);
                    chk("score", score_o, e.score);
                    chk("latency_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        logic [287:0] g0;
        reset_ni = 1'b0;
        N_id_i = '0;
        N_id_valid_i = 1'b0;
        s_axis_in_tdata = '0;
        s_axis_in_tvalid = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("rst_tvalid", m_axis_out_tvalid, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_tdata", m_axis_out_tdata, 0);
        chk("rst_score", score_o, 0);
        reset_ni = 1'b1;

        // noiseless, no gaps, plus Gold probe on the first CORR bits
        run(0, 0, 0, 1'b0, 1'b1);
        g0 = gold(cinit_of(0, 0));
        for (int j = 0; j < 4; j++) begin
            wait_cyc(acc + NC + 1 + j);
            chk($sformatf("gold_c%0d", j), dut.x1_q[0] ^ dut.x2_q[0], g0[j]);
        end
        drain();

        run(1007, 5, 0, 1'b1, 1'b1);
        drain();

        run(433, 7, 10, 1'b0, 1'b1);
        drain();

        // a full SSB streamed while idle must be ignored
        build(100, 2, 0);
        send_res(1'b0);
        chk("busy_after_idle_stream", busy_o, 0);
        run(100, 2, 0, 1'b0, 1'b1);
        drain();

        // reset during WARMUP of hypothesis 4 abandons the search
        run(500, 3, 0, 1'b0, 1'b0);
        wait_cyc(acc + 4 * (NC + 290) + 1 + NC / 2);
        reset_ni = 1'b0;
        #1;
        chk("midrst_busy", busy_o, 0);
        chk("midrst_tvalid", m_axis_out_tvalid, 0);
        chk("midrst_tdata", m_axis_out_tdata, 0);
        chk("midrst_score", score_o, 0);
        repeat (2) @(negedge clk_i);
        reset_ni = 1'b1;

        run(1, 6, 0, 1'b0, 1'b1);
        drain();

        repeat (20) @(posedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
